central_core_v2: RTL and testbench
==================================

// Module: central_core_v2
// PURPOSE
//  Parametrised accumulator CPU core with unified on-chip memory, successor to the central core.
//  Adds sync reset, an external program-load port, a run/halt handshake, HLT and illegal-opcode handling.
//  Memory words [0,PROGRAM_SIZE) hold program; [PROGRAM_SIZE,2**ADDR_SIZE) hold data (low DATA_SIZE bits).
// PARAMETERS
//  INSTR_SIZE   12  instruction/memory word width; instr = {opcode, operand}
//  DATA_SIZE    8   accumulator/data width
//  OPCODE_SIZE  4   opcode field width (MSBs of instr)
//  ADDR_SIZE    5   memory address width; depth = 2**ADDR_SIZE
//  PROGRAM_SIZE 16  program region size; must be < 2**ADDR_SIZE
// PORTS
//  clk            in   1           clock, rising edge
//  rst            in   1           synchronous, active-high reset
//  load_en        in   1           write load_data to mem[load_addr] this cycle
//  load_addr      in   ADDR_SIZE   program-load address
//  load_data      in   INSTR_SIZE  program-load word
//  run            in   1           start execution at PC=0
//  halted         out  1           core stopped by HLT
//  out_of_bounds  out  1           sticky fault: PC or store address outside permitted region
//  acc_out        out  DATA_SIZE   accumulator
//  pc_out         out  ADDR_SIZE   program counter
// BEHAVIOUR
//  Reset: state IDLE, pc=0, acc=0, halted=0, out_of_bounds=0; memory contents not cleared.
//  FSM: IDLE -> FETCH -> EXEC [-> MEM] -> FETCH ...; terminal states HALT, FAULT.
//  - IDLE/HALT/FAULT: load_en writes memory. run (with load_en=0) -> pc=0, acc=0, flags clear, FETCH.
//    load_en and run in the same cycle: load done, run ignored.
//  - RUN states: load_en and run ignored.
//  - FETCH: if pc>=PROGRAM_SIZE -> FAULT, out_of_bounds=1. Else sync read mem[pc] -> EXEC.
//  - EXEC: decode; pc<=pc+1 unless jump taken. Memory-read ops issue read -> MEM. Others -> FETCH.
//  - MEM: apply read data to acc -> FETCH.
//  - Latency: 2 cycles/instr; LDA/ADD/SUB/AND 3 cycles.
//  Operand fields:
//  - addr = operand[ADDR_SIZE-1:0].
//  - imm = operand sign-extended or truncated to DATA_SIZE.
//  Arithmetic is modulo 2**DATA_SIZE; no carry flag.
//  N = acc[DATA_SIZE-1]; Z = (acc==0).
//  ISA:
//   0 NOP   1 LDA acc=mem[a]   2 ADD acc+=mem[a]   3 SUB acc-=mem[a]   4 AND acc&=mem[a]
//   5 LDI acc=imm   6 ADDI acc+=imm   7 STA mem[a]=acc (zero-extended to INSTR_SIZE)
//   8 JMP pc=a   9 JN if N pc=a   A JZ if Z pc=a   F HLT -> HALT, halted=1
//  STA with a<PROGRAM_SIZE: write suppressed, out_of_bounds=1 -> FAULT.
//  Jump targets are not checked at jump time; they are caught at the next FETCH.
//  pc wraps at 2**ADDR_SIZE.
//  halted and out_of_bounds are held until rst or the next accepted run.
//  rst during any state aborts the instruction: no memory write that cycle; outputs take reset values next edge.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//  - Opcodes B-E -> FAULT with out_of_bounds=1.
//  - pc stays at the faulting instruction.
//  ILLEGAL_TRAP_EN undefined: opcodes B-E execute as NOP in 2 cycles.
// TESTING
//  1. Reset, then check outputs -> halted=0, oob=0, acc_out=0, pc_out=0.
//  2. Load countdown program and run:
//     LDI 5; STA 17; ADDI -1; JN 5; JMP 1; HLT.
//     Expect mem[17]=0, acc=0xFF, halted=1, pc_out=6.
//  3. Load "ADDI 0x7F; ADDI 1; HLT" and run -> acc=0x80 (wrap), N set; next JN taken if appended.
//  4. STA 3 from program -> no write to mem[3], out_of_bounds=1, state FAULT.
//     Then load_en accepted; run clears fault.
//  5. Program with no HLT, falling off end -> FETCH at pc=16 -> out_of_bounds=1.
//     Assert load_en mid-run -> memory unchanged.
//  6. Opcode 0xB: trap on/off.
//     With ILLEGAL_TRAP_EN -> FAULT, pc_out holds the faulting pc.
//     Without it -> treated as NOP.
//     Assert rst mid-MEM -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/central_core_v2.sv
// Accumulator CPU core with unified program/data memory, a program-load port and a run/halt handshake.
// Optional feature macro: ILLEGAL_TRAP_EN (opcodes B-E fault instead of executing as NOP).
module central_core_v2 #(
    parameter int INSTR_SIZE   = 12,
    parameter int DATA_SIZE    = 8,
    parameter int OPCODE_SIZE  = 4,
    parameter int ADDR_SIZE    = 5,
    parameter int PROGRAM_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [ADDR_SIZE-1:0]  load_addr,
    input  logic [INSTR_SIZE-1:0] load_data,
    input  logic                  run,
    output logic                  halted,
    output logic                  out_of_bounds,
    output logic [DATA_SIZE-1:0]  acc_out,
    output logic [ADDR_SIZE-1:0]  pc_out
);

    localparam int OPERAND_SIZE = INSTR_SIZE - OPCODE_SIZE;
    localparam int DEPTH        = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE-1:0] PROG_END = ADDR_SIZE'(PROGRAM_SIZE);

    localparam logic [OPCODE_SIZE-1:0] OP_NOP  = OPCODE_SIZE'(4'h0);
    localparam logic [OPCODE_SIZE-1:0] OP_LDA  = OPCODE_SIZE'(4'h1);
    localparam logic [OPCODE_SIZE-1:0] OP_ADD  = OPCODE_SIZE'(4'h2);
    localparam logic [OPCODE_SIZE-1:0] OP_SUB  = OPCODE_SIZE'(4'h3);
    localparam logic [OPCODE_SIZE-1:0] OP_AND  = OPCODE_SIZE'(4'h4);
    localparam logic [OPCODE_SIZE-1:0] OP_LDI  = OPCODE_SIZE'(4'h5);
    localparam logic [OPCODE_SIZE-1:0] OP_ADDI = OPCODE_SIZE'(4'h6);
    localparam logic [OPCODE_SIZE-1:0] OP_STA  = OPCODE_SIZE'(4'h7);
    localparam logic [OPCODE_SIZE-1:0] OP_JMP  = OPCODE_SIZE'(4'h8);
    localparam logic [OPCODE_SIZE-1:0] OP_JN   = OPCODE_SIZE'(4'h9);
    localparam logic [OPCODE_SIZE-1:0] OP_JZ   = OPCODE_SIZE'(4'hA);
    localparam logic [OPCODE_SIZE-1:0] OP_HLT  = OPCODE_SIZE'(4'hF);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    // Sign-extends a narrow operand or truncates a wide one to the accumulator width.
    function automatic logic [DATA_SIZE-1:0] imm_ext(input logic [OPERAND_SIZE-1:0] op);
        logic [DATA_SIZE+OPERAND_SIZE-1:0] wide;
        wide = {{DATA_SIZE{op[OPERAND_SIZE-1]}}, op};
        return wide[DATA_SIZE-1:0];
    endfunction

    state_t                  state_r;
    logic [INSTR_SIZE-1:0]   mem_r [DEPTH];
    logic [INSTR_SIZE-1:0]   instr_r;
    logic [DATA_SIZE-1:0]    rdata_r;
    logic [ADDR_SIZE-1:0]    pc_r;
    logic [DATA_SIZE-1:0]    acc_r;
    logic                    halted_r;
    logic                    oob_r;

    logic [OPCODE_SIZE-1:0]  opcode_s;
    logic [OPERAND_SIZE-1:0] operand_s;
    logic [ADDR_SIZE-1:0]    addr_s;
    logic [DATA_SIZE-1:0]    imm_s;
    logic                    stopped_s;
    logic                    sta_bad_s;
    logic                    mem_we_s;
    logic [ADDR_SIZE-1:0]    mem_waddr_s;
    logic [INSTR_SIZE-1:0]   mem_wdata_s;

    assign opcode_s  = instr_r[INSTR_SIZE-1 -: OPCODE_SIZE];
    assign operand_s = instr_r[OPERAND_SIZE-1:0];
    assign addr_s    = operand_s[ADDR_SIZE-1:0];
    assign imm_s     = imm_ext(operand_s);
    assign stopped_s = (state_r == S_IDLE) || (state_r == S_HALT) || (state_r == S_FAULT);
    assign sta_bad_s = (addr_s < PROG_END);

    // Memory write arbitration: program load while stopped, STA while executing; reset blocks both.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = load_addr;
        mem_wdata_s = load_data;
        if (rst) begin
            mem_we_s = 1'b0;
        end else if (stopped_s && load_en) begin
            mem_we_s = 1'b1;
        end else if ((state_r == S_EXEC) && (opcode_s == OP_STA) && !sta_bad_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = addr_s;
            mem_wdata_s = INSTR_SIZE'(acc_r);
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Unified memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Core sequencer: fetch, execute and memory-operand stages plus the stopped states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            pc_r     <= '0;
            acc_r    <= '0;
            halted_r <= 1'b0;
            oob_r    <= 1'b0;
            instr_r  <= '0;
            rdata_r  <= '0;
        end else begin
            case (state_r)
                S_IDLE, S_HALT, S_FAULT: begin
                    if (!load_en && run) begin
                        pc_r     <= '0;
                        acc_r    <= '0;
                        halted_r <= 1'b0;
                        oob_r    <= 1'b0;
                        state_r  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (pc_r >= PROG_END) begin
                        oob_r   <= 1'b1;
                        state_r <= S_FAULT;
                    end else begin
                        instr_r <= mem_r[pc_r];
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_r <= S_FETCH;
                    pc_r    <= pc_r + ADDR_SIZE'(1);
                    case (opcode_s)
                        OP_NOP: begin
                        end
                        OP_LDA, OP_ADD, OP_SUB, OP_AND: begin
                            rdata_r <= mem_r[addr_s][DATA_SIZE-1:0];
                            state_r <= S_MEM;
                        end
                        OP_LDI:  acc_r <= imm_s;
                        OP_ADDI: acc_r <= acc_r + imm_s;
                        OP_STA: begin
                            // Stores into the program region are refused and latch a fault.
                            if (sta_bad_s) begin
                                oob_r   <= 1'b1;
                                state_r <= S_FAULT;
                            end
                        end
                        OP_JMP: pc_r <= addr_s;
                        OP_JN: begin
                            if (acc_r[DATA_SIZE-1]) pc_r <= addr_s;
                        end
                        OP_JZ: begin
                            if (acc_r == '0) pc_r <= addr_s;
                        end
                        OP_HLT: begin
                            halted_r <= 1'b1;
                            state_r  <= S_HALT;
                        end
                        default: begin
`ifdef ILLEGAL_TRAP_EN
                            oob_r   <= 1'b1;
                            pc_r    <= pc_r;
                            state_r <= S_FAULT;
`else
                            state_r <= S_FETCH;
`endif
                        end
                    endcase
                end
                S_MEM: begin
                    state_r <= S_FETCH;
                    case (opcode_s)
                        OP_LDA:  acc_r <= rdata_r;
                        OP_ADD:  acc_r <= acc_r + rdata_r;
                        OP_SUB:  acc_r <= acc_r - rdata_r;
                        OP_AND:  acc_r <= acc_r & rdata_r;
                        default: acc_r <= acc_r;
                    endcase
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign halted        = halted_r;
    assign out_of_bounds = oob_r;
    assign acc_out       = acc_r;
    assign pc_out        = pc_r;

endmodule

// File: tb/tb_central_core_v2.sv
// Directed-vector bench for central_core_v2; expected values are hand-computed from the ISA.
module tb_central_core_v2;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [11:0] load_data;
    logic        run;
    logic        halted;
    logic        out_of_bounds;
    logic [7:0]  acc_out;
    logic [4:0]  pc_out;

    int n_checks = 0;
    int n_pass   = 0;

    central_core_v2 dut (
        .clk           (clk),
        .rst           (rst),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .run           (run),
        .halted        (halted),
        .out_of_bounds (out_of_bounds),
        .acc_out       (acc_out),
        .pc_out        (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] a, input logic [11:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    task automatic start();
        run = 1'b1;
        step();
        run = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!(halted || out_of_bounds) && n < 400) begin
            step();
            n++;
        end
        chk(tag, 32'(halted | out_of_bounds), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        load_en   = 1'b0;
        load_addr = 5'd0;
        load_data = 12'h000;
        run       = 1'b0;
        step();
        step();
        rst = 1'b0;

        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_oob",    32'(out_of_bounds), 32'd0);
        chk("rst_acc",    32'(acc_out), 32'h0);
        chk("rst_pc",     32'(pc_out), 32'h0);

        // Countdown: LDI 5; STA 17; ADDI -1; JN 5; JMP 1; HLT
        load(5'd17, 12'h0AA);
        load(5'd0, 12'h505);
        load(5'd1, 12'h711);
        load(5'd2, 12'h6FF);
        load(5'd3, 12'h905);
        load(5'd4, 12'h801);
        load(5'd5, 12'hF00);
        start();
        wait_done("cd_done");
        chk("cd_acc",    32'(acc_out), 32'hFF);
        chk("cd_halted", 32'(halted), 32'd1);
        chk("cd_pc",     32'(pc_out), 32'd6);
        chk("cd_oob",    32'(out_of_bounds), 32'd0);

        // load_en and run together: load happens, run is ignored
        load_en   = 1'b1;
        run       = 1'b1;
        load_addr = 5'd0;
        load_data = 12'h555;
        step();
        load_en = 1'b0;
        run     = 1'b0;
        step();
        step();
        chk("ldrun_halted", 32'(halted), 32'd1);
        chk("ldrun_pc",     32'(pc_out), 32'd6);

        // Readback mem[17] via LDI 0x55; ADD 17; HLT
        load(5'd1, 12'h211);
        load(5'd2, 12'hF00);
        start();
        wait_done("rb17_done");
        chk("rb17_acc", 32'(acc_out), 32'h55);

        // Wrap: ADDI 7F; ADDI 1; JN 4; HLT; HLT
        load(5'd0, 12'h67F);
        load(5'd1, 12'h601);
        load(5'd2, 12'h904);
        load(5'd3, 12'hF00);
        load(5'd4, 12'hF00);
        start();
        wait_done("wrap_done");
        chk("wrap_acc",    32'(acc_out), 32'h80);
        chk("wrap_pc",     32'(pc_out), 32'd5);
        chk("wrap_halted", 32'(halted), 32'd1);

        // STA into program region: LDI 0x42; STA 3; HLT
        load(5'd3, 12'h0A5);
        load(5'd0, 12'h542);
        load(5'd1, 12'h703);
        load(5'd2, 12'hF00);
        start();
        wait_done("sta_done");
        chk("sta_oob",    32'(out_of_bounds), 32'd1);
        chk("sta_halted", 32'(halted), 32'd0);
        chk("sta_acc",    32'(acc_out), 32'h42);
        load(5'd0, 12'h103);
        load(5'd1, 12'hF00);
        start();
        wait_done("rb3_done");
        chk("rb3_acc",    32'(acc_out), 32'hA5);
        chk("rb3_oob",    32'(out_of_bounds), 32'd0);
        chk("rb3_halted", 32'(halted), 32'd1);

        // Fall off the program region; a mid-run load must be ignored
        load(5'd20, 12'h033);
        for (int i = 0; i < 16; i++) load(5'(i), 12'h601);
        start();
        step();
        step();
        step();
        load(5'd20, 12'h0CC);
        wait_done("off_done");
        chk("off_oob", 32'(out_of_bounds), 32'd1);
        chk("off_pc",  32'(pc_out), 32'd16);
        chk("off_acc", 32'(acc_out), 32'h10);
        load(5'd0, 12'h114);
        load(5'd1, 12'hF00);
        start();
        wait_done("rb20_done");
        chk("rb20_acc", 32'(acc_out), 32'h33);

        // Opcode 0xB: LDI 3; 0xB00; ADDI 1; HLT
        load(5'd0, 12'h503);
        load(5'd1, 12'hB00);
        load(5'd2, 12'h601);
        load(5'd3, 12'hF00);
        start();
        wait_done("ill_done");
`ifdef ILLEGAL_TRAP_EN
        chk("ill_acc", 32'(acc_out), 32'h03);
        chk("ill_pc",  32'(pc_out), 32'd1);
        chk("ill_oob", 32'(out_of_bounds), 32'd1);
`else
        chk("ill_acc", 32'(acc_out), 32'h04);
        chk("ill_pc",  32'(pc_out), 32'd4);
        chk("ill_oob", 32'(out_of_bounds), 32'd0);
`endif

        // Reset while in MEM: LDI 7; LDA 20; HLT
        load(5'd0, 12'h507);
        load(5'd1, 12'h114);
        load(5'd2, 12'hF00);
        start();
        step();
        step();
        step();
        step();
        chk("mem_acc", 32'(acc_out), 32'h07);
        chk("mem_pc",  32'(pc_out), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_acc",    32'(acc_out), 32'h0);
        chk("mrst_pc",     32'(pc_out), 32'd0);
        chk("mrst_halted", 32'(halted), 32'd0);
        chk("mrst_oob",    32'(out_of_bounds), 32'd0);
        step();
        step();
        chk("idle_pc",  32'(pc_out), 32'd0);
        chk("idle_acc", 32'(acc_out), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
